unified_mem_responder: RTL and testbench
========================================

UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning byte-address width; memory depth is 2^ADDR_W bytes.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied fetch cycles after which fetch wins arbitration.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, declared as the following ports:
  clk  in  1  rising-edge clock, the only clock
  rst  in  1  asynchronous reset, active high
REQ-004 The block SHALL have the following instruction-fetch port:
  i_req  in  1  fetch request
  i_addr  in  ADDR_W  fetch byte address
  i_gnt  out  1  fetch accepted this cycle (combinational)
  i_rvalid  out  1  i_rdata valid
  i_rdata  out  32  fetched word
REQ-005 The block SHALL have the following data port:
  d_req  in  1  data request
  d_we  in  1  1 = store, 0 = load
  d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
  d_signed  in  1  sign-extend load
  d_addr  in  ADDR_W  data byte address
  d_wdata  in  32  store data, right-aligned
  d_gnt  out  1  data accepted this cycle (combinational)
  d_rvalid  out  1  load data or store acknowledge valid
  d_rdata  out  32  load result, zero for stores
  d_err  out  1  misaligned access flag, valid with d_rvalid

Function
REQ-006 The block SHALL accept at most one request per cycle into its single-ported byte array; a request is accepted when req and gnt are both 1 at a rising clk edge.
REQ-007 Arbitration SHALL give fixed priority to the data port, unless the starvation counter equals STARVE_MAX and i_req=1, in which case fetch SHALL be granted.
REQ-008 The starvation counter SHALL increment when i_req=1 and i_gnt=0, clear when i_gnt=1 or i_req=0, and saturate at STARVE_MAX.
REQ-009 Response latency SHALL be exactly 1 cycle: an accept at edge N SHALL assert the matching rvalid for the cycle following edge N, for exactly one cycle; there is no back-pressure.
REQ-010 The response FSM SHALL have the states RSP_IDLE, RSP_I and RSP_D, and SHALL move each edge to RSP_I on a fetch accept, to RSP_D on a data accept, and to RSP_IDLE otherwise; back-to-back accepts SHALL be supported with no bubble.
REQ-011 Memory layout SHALL be little-endian; a word is formed as {mem[a+3],mem[a+2],mem[a+1],mem[a]}, and the address wraps modulo 2^ADDR_W.
REQ-012 Stores SHALL write 1, 2 or 4 bytes per d_size from the low bytes of d_wdata at the accept edge, and a same-cycle-following fetch of that address SHALL return the new data.
REQ-013 Loads SHALL return byte or half data zero-extended when d_signed=0 and sign-extended when d_signed=1; word loads SHALL ignore d_signed.
REQ-014 When a request is not accepted, the requester SHALL hold it; the block SHALL NOT queue requests.
REQ-015 i_rdata and d_rdata SHALL hold their last value while the corresponding rvalid=0.

Reset
REQ-016 rst=1 SHALL asynchronously force the following: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, d_err=0, starvation counter=0, FSM=RSP_IDLE.
REQ-017 Byte-array contents SHALL NOT be reset.
REQ-018 An accept pending when rst asserts SHALL be discarded without a response, and a store not yet written SHALL be lost.
REQ-019 While rst=1, i_gnt and d_gnt SHALL be 0.

Configuration
REQ-020 The macro MISALIGN_CHECK_EN SHALL control misaligned-access checking, where misaligned means half at an odd address or word at an address not divisible by 4.
REQ-021 With MISALIGN_CHECK_EN defined, a misaligned data access SHALL set d_err=1 with its d_rvalid, and a misaligned store SHALL NOT modify memory.
REQ-022 Without MISALIGN_CHECK_EN, d_err SHALL be tied to 0 and misaligned accesses SHALL proceed with wrapped byte addressing.

Structure
REQ-023 The shared package SHALL hold the d_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state constants.
REQ-024 The byte array SHALL be the sub-module mem_byte_array, providing a 4-lane byte-enable write and a 32-bit little-endian read.

Verification
REQ-025 After reset, the bench SHALL store word 0xDEADBEEF at 0x10, then load word 0x10 -> d_rvalid 1 cycle later with d_rdata=0xDEADBEEF.
REQ-026 The bench SHALL issue a signed byte load at 0x13 -> d_rdata=0xFFFFFFDE; an unsigned half load at 0x12 -> 0x0000DEAD.
REQ-027 The bench SHALL hold i_req=1 and d_req=1 for 6 cycles -> d_gnt for cycles 1-4, i_gnt in cycle 5, d_gnt in cycle 6.
REQ-028 The bench SHALL fetch at 0xFE with a word request -> bytes read from 0xFE, 0xFF, 0x00, 0x01 (wrap), with d_err=1 only if MISALIGN_CHECK_EN is defined.
REQ-029 The bench SHALL assert rst in the cycle after a load accept -> no d_rvalid, all outputs 0, and the memory at 0x10 still reading 0xDEADBEEF after reset.

Source files
------------

// File: rtl/unified_mem_responder_pkg.sv
// Shared definitions for unified_mem_responder.
//   - d_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is treated as word)
//   - response FSM states (RSP_IDLE, RSP_I, RSP_D)
//   - helpers for store byte enables and load lane extraction
package unified_mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'b00,
        RSP_I    = 2'b01,
        RSP_D    = 2'b10
    } rsp_state_e;

    // Store byte enables, relative to the access address.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001;
            SZ_HALF: be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Trim a little-endian word read at the access address to the load size.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sign_ext);
        logic [31:0] res;
        case (size)
            SZ_BYTE: res = {{24{sign_ext & word[7]}}, word[7:0]};
            SZ_HALF: res = {{16{sign_ext & word[15]}}, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/unified_mem_responder_mem_byte_array.sv
// mem_byte_array: 2^ADDR_W byte array, one 4-lane byte-enable write port and
// one 32-bit little-endian combinational read port. Lane k maps to byte
// address addr+k, wrapping modulo 2^ADDR_W. Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   be     in   [3:0]  byte-lane enables
//   addr   in   [ADDR_W-1:0] byte address (read and write)
//   wdata  in   [31:0] write data, lane k = wdata[8k+7:8k]
//   rdata  out  [31:0] {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}
module mem_byte_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[addr + ADDR_W'(k)] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            rdata[8*k +: 8] = mem[addr + ADDR_W'(k)];
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: single-ported byte memory shared by an instruction
// fetch port and a data port. One accept per cycle, fixed data priority with
// an anti-starvation override for fetch, fixed one-cycle response latency.
// Optional macro: MISALIGN_CHECK_EN -- flags misaligned data accesses via
// d_err and suppresses misaligned stores. Without it d_err is 0 and
// misaligned accesses use wrapped byte addressing.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_req, i_addr                fetch request / byte address
//   i_gnt                        fetch accepted this cycle (combinational)
//   i_rvalid, i_rdata            fetch response, data held while not valid
//   d_req, d_we, d_size,         data request, store flag, size,
//   d_signed, d_addr, d_wdata    sign-extend flag, byte address, store data
//   d_gnt                        data accepted this cycle (combinational)
//   d_rvalid, d_rdata, d_err     data response, load data (0 for stores),
//                                misaligned flag
module unified_mem_responder
    import unified_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    rsp_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [31:0]      i_rdata_q, d_rdata_q;
    logic             fetch_wins;
    logic             misaligned;
    logic             mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]      mem_rdata;

    // Arbitration: data first, unless fetch has waited STARVE_MAX cycles.
    always_comb begin
        fetch_wins = i_req && (starve_q == STARVE_LIM);
        i_gnt      = !rst && i_req && (!d_req || fetch_wins);
        d_gnt      = !rst && d_req && !fetch_wins;
    end

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misaligned = ((d_size == SZ_HALF) && d_addr[0]) ||
                     (d_size[1] && (d_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        misaligned = 1'b0;
    end
`endif

    // Read and write share one address; only one port is accepted per cycle.
    always_comb begin
        mem_addr = i_gnt ? i_addr : d_addr;
        mem_we   = d_gnt && d_we && !misaligned;
    end

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (size_to_be(d_size)),
        .addr  (mem_addr),
        .wdata (d_wdata),
        .rdata (mem_rdata)
    );

    // Response FSM: the state itself is the rvalid of the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RSP_IDLE;
        if (i_gnt) begin
            state_d = RSP_I;
        end else if (d_gnt) begin
            state_d = RSP_D;
        end
        i_rvalid = (state_q == RSP_I);
        d_rvalid = (state_q == RSP_D);
    end

    // Read data is captured at the accept edge, so a store accepted on the
    // previous edge is already visible, and data holds until the next accept.
    // Misaligned loads still return the wrapped data alongside d_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            if (i_gnt) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_gnt) begin
                d_rdata_q <= d_we ? 32'd0 : load_extract(mem_rdata, d_size, d_signed);
            end
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

`ifdef MISALIGN_CHECK_EN
    logic d_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_err_q <= 1'b0;
        end else if (d_gnt) begin
            d_err_q <= misaligned;
        end
    end

    assign d_err = d_err_q;
`else
    assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized self-checking bench for unified_mem_responder with a byte-array
// reference model and directed checks for the documented scenarios.
module tb_unified_mem_responder;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned STARVE_MAX = 4;
`ifdef MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    unified_mem_responder #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_signed (d_signed),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference state
    logic [7:0]  mem_m [256];
    int          starve_m;
    logic        exp_iv, exp_dv, exp_derr;
    logic [31:0] exp_id, exp_dd;
    logic        m_ig, m_dg;
    logic        obs_ig, obs_dg;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [31:0] w;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ak;
            ak = a + 8'(k);
            w = w + (32'(mem_m[ak]) << (8 * k));
        end
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] sz,
                                               input logic sg);
        logic [31:0] w;
        int unsigned v;
        w = model_word(a);
        if (sz == 2'd0) begin
            v = w % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = w % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit model_misal(input logic [7:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    endfunction

    // One clock cycle: drive at negedge, check grants, check responses after edge.
    task automatic step(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [1:0] dsz, input logic dsg, input logic [7:0] da,
                        input logic [31:0] dwd);
        bit fw, mis;
        int nb;
        @(negedge clk);
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_size = dsz; d_signed = dsg; d_addr = da; d_wdata = dwd;
        #1;
        fw   = ir && (starve_m == STARVE_MAX);
        m_ig = ir && (!dr || fw);
        m_dg = dr && !fw;
        obs_ig = i_gnt;
        obs_dg = d_gnt;
        check_val("i_gnt", {31'd0, i_gnt}, {31'd0, m_ig});
        check_val("d_gnt", {31'd0, d_gnt}, {31'd0, m_dg});
        @(posedge clk);
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        if (m_ig) begin
            exp_iv = 1'b1;
            exp_id = model_word(ia);
        end else if (m_dg) begin
            exp_dv   = 1'b1;
            mis      = model_misal(da, dsz);
            exp_derr = CHECK_EN && mis;
            if (dw) begin
                exp_dd = 0;
                if (!(CHECK_EN && mis)) begin
                    nb = (dsz == 2'd0) ? 1 : (dsz == 2'd1) ? 2 : 4;
                    for (int k = 0; k < nb; k++) begin
                        logic [7:0] ak;
                        ak = da + 8'(k);
                        mem_m[ak] = 8'((dwd >> (8 * k)) % 256);
                    end
                end
            end else begin
                exp_dd = model_load(da, dsz, dsg);
            end
        end
        if (!ir || m_ig) starve_m = 0;
        else if (starve_m < STARVE_MAX) starve_m++;
        #1;
        check_val("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_iv});
        check_val("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dv});
        check_val("i_rdata", i_rdata, exp_id);
        check_val("d_rdata", d_rdata, exp_dd);
        if (exp_dv) check_val("d_err", {31'd0, d_err}, {31'd0, exp_derr});
    endtask

    task automatic reset_outputs_zero(input string tag);
        check_val({tag, "_i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
        check_val({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
        check_val({tag, "_i_rdata"}, i_rdata, 32'd0);
        check_val({tag, "_d_rdata"}, d_rdata, 32'd0);
        check_val({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
        check_val({tag, "_i_gnt"}, {31'd0, i_gnt}, 32'd0);
        check_val({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
    endtask

    logic        pi, pd, pdw, pdsg;
    logic [7:0]  pia, pda;
    logic [1:0]  pdsz;
    logic [31:0] pdwd;
    logic        arb_i [6];

    initial begin
        vectors = 0;
        miscompares = 0;
        starve_m = 0;
        exp_iv = 0; exp_dv = 0; exp_derr = 0; exp_id = 0; exp_dd = 0;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 0;
        d_req = 1'b1; d_we = 0; d_size = 0; d_signed = 0; d_addr = 0; d_wdata = 0;
        #2;
        reset_outputs_zero("por");
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fill memory so every model byte is known.
        for (int a = 0; a < 64; a++) step(0, 0, 1, 1, 2'd2, 0, 8'(a * 4), $urandom);

        // Word store / load, then narrow loads from the same word.
        step(0, 0, 1, 1, 2'd2, 0, 8'h10, 32'hDEADBEEF);
        step(0, 0, 1, 0, 2'd2, 0, 8'h10, 0);
        check_val("ld_word_10", d_rdata, 32'hDEADBEEF);
        step(0, 0, 1, 0, 2'd0, 1, 8'h13, 0);
        check_val("ld_sbyte_13", d_rdata, 32'hFFFFFFDE);
        step(0, 0, 1, 0, 2'd1, 0, 8'h12, 0);
        check_val("ld_uhalf_12", d_rdata, 32'h0000DEAD);

        // Starvation override with both ports held for 6 cycles.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            step(1, 8'h20, 1, 0, 2'd2, 0, 8'h10, 0);
            arb_i[c] = obs_ig;
            check_val("arb_d_gnt", {31'd0, obs_dg}, (c == 4) ? 32'd0 : 32'd1);
        end
        for (int c = 0; c < 6; c++) check_val("arb_i_gnt", {31'd0, arb_i[c]},
                                              (c == 4) ? 32'd1 : 32'd0);

        // Wrap-around word at 0xFE on both ports.
        step(0, 0, 1, 1, 2'd0, 0, 8'hFE, 32'h11);
        step(0, 0, 1, 1, 2'd0, 0, 8'hFF, 32'h22);
        step(0, 0, 1, 1, 2'd0, 0, 8'h00, 32'h33);
        step(0, 0, 1, 1, 2'd0, 0, 8'h01, 32'h44);
        step(0, 0, 1, 0, 2'd2, 0, 8'hFE, 0);
        check_val("ld_wrap_fe", d_rdata, 32'h44332211);
        check_val("err_wrap_fe", {31'd0, d_err}, {31'd0, CHECK_EN});
        step(1, 8'hFE, 0, 0, 0, 0, 0, 0);
        check_val("if_wrap_fe", i_rdata, 32'h44332211);

        // Store immediately followed by a fetch of the same word.
        step(0, 0, 1, 1, 2'd2, 0, 8'h40, 32'hCAFEF00D);
        step(1, 8'h40, 0, 0, 0, 0, 0, 0);
        check_val("st_then_if", i_rdata, 32'hCAFEF00D);

        // Random traffic; requesters hold un-granted requests.
        pi = 0; pd = 0;
        pia = 0; pda = 0; pdw = 0; pdsz = 0; pdsg = 0; pdwd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pi) begin
                pi  = ($urandom % 3) != 0;
                pia = 8'($urandom);
            end
            if (!pd) begin
                pd   = ($urandom % 3) != 0;
                pdw  = 1'($urandom);
                pdsz = 2'($urandom);
                pdsg = 1'($urandom);
                pda  = 8'($urandom);
                pdwd = $urandom;
            end
            step(pi, pia, pd, pdw, pdsz, pdsg, pda, pdwd);
            if (m_ig) pi = 0;
            if (m_dg) pd = 0;
        end

        // Reset in the cycle after a load accept: response dropped, memory kept.
        step(0, 0, 1, 1, 2'd2, 0, 8'h10, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 8'h10;
        @(posedge clk);
        rst = 1'b1;
        i_req = 1'b1;
        #1;
        reset_outputs_zero("rst_mid");
        exp_iv = 0; exp_dv = 0; exp_id = 0; exp_dd = 0; starve_m = 0;
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 2'd2, 0, 8'h10, 0);
        check_val("ld_after_rst", d_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
